// File: rtl/corelet_ctrl.sv
// rtl/corelet_ctrl.sv - one-pass weight/activation sequencer for a corelet
// Optional CORELET_CTRL_PERF_EN adds the perf_cycles_o busy-cycle counter.
module corelet_ctrl #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int len_bw  = 6
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 start_i,
  input  logic [addr_bw-1:0]   w_base_i,
  input  logic [addr_bw-1:0]   x_base_i,
  input  logic [len_bw-1:0]    len_i,
  output logic                 mem_cen_o,
  output logic [addr_bw-1:0]   mem_addr_o,
  input  logic [row*bw-1:0]    mem_rdata_i,
  output logic [33:0]          inst_o,
  output logic [row*bw-1:0]    l0_input_o,
  output logic                 xw_mode_o,
  output logic                 sfp_reset_o,
  input  logic                 ofifo_valid_i,
  output logic                 busy_o,
  output logic                 done_o
`ifdef CORELET_CTRL_PERF_EN
  ,output logic [31:0]         perf_cycles_o
`endif
);

  localparam int CNT_W = ((len_bw + 1) > $clog2(row + col + 2)) ? (len_bw + 1)
                                                                 : $clog2(row + col + 2);
  localparam logic [CNT_W-1:0] COL_C      = CNT_W'(col);
  localparam logic [CNT_W-1:0] COL_LAST   = CNT_W'(col - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(row + col - 1);

  generate
    if (psum_bw < bw) begin : g_bad_psum
      $error("psum_bw must be at least bw");
    end
  endgenerate

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_WFETCH, S_WLOAD, S_WFLUSH, S_XFETCH, S_EXEC, S_DRAIN, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [len_bw-1:0]  pop_q, pop_d;
  logic [addr_bw-1:0] w_base_q, w_base_d, x_base_q, x_base_d;
  logic [len_bw-1:0]  len_q, len_d;
  logic [CNT_W-1:0]   len_ext;

  assign len_ext    = CNT_W'(len_q);
  assign l0_input_o = mem_rdata_i;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      pop_q    <= '0;
      w_base_q <= '0;
      x_base_q <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pop_q    <= pop_d;
      w_base_q <= w_base_d;
      x_base_q <= x_base_d;
      len_q    <= len_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pop_d       = pop_q;
    w_base_d    = w_base_q;
    x_base_d    = x_base_q;
    len_d       = len_q;
    mem_cen_o   = 1'b1;
    mem_addr_o  = '0;
    inst_o      = '0;
    xw_mode_o   = 1'b0;
    sfp_reset_o = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        cnt_d  = '0;
        pop_d  = '0;
        if (start_i) begin
          if (len_i != '0) begin
            w_base_d = w_base_i;
            x_base_d = x_base_i;
            len_d    = len_i;
            state_d  = S_CLEAR;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_CLEAR: begin
        sfp_reset_o = 1'b1;
        state_d     = S_WFETCH;
      end
      // Reads in counts 0..col-1; each word lands in L0 on the following count.
      S_WFETCH: begin
        xw_mode_o = 1'b1;
        if (cnt_q < COL_C) begin
          mem_cen_o  = 1'b0;
          mem_addr_o = w_base_q + addr_bw'(cnt_q);
        end
        inst_o[2] = (cnt_q != '0);
        if (cnt_q == COL_C) begin
          cnt_d   = '0;
          state_d = S_WLOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WLOAD: begin
        xw_mode_o = 1'b1;
        inst_o[3] = 1'b1;
        inst_o[0] = 1'b1;
        if (cnt_q == COL_LAST) begin
          cnt_d   = '0;
          state_d = S_WFLUSH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WFLUSH: begin
        xw_mode_o = 1'b1;
        if (cnt_q == FLUSH_LAST) begin
          cnt_d   = '0;
          state_d = S_XFETCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_XFETCH: begin
        if (cnt_q < len_ext) begin
          mem_cen_o  = 1'b0;
          mem_addr_o = x_base_q + addr_bw'(cnt_q);
        end
        inst_o[2] = (cnt_q != '0);
        if (cnt_q == len_ext) begin
          cnt_d   = '0;
          state_d = S_EXEC;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EXEC: begin
        inst_o[3] = 1'b1;
        inst_o[1] = 1'b1;
        pop_d     = '0;
        if (cnt_q == len_ext - 1'b1) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (ofifo_valid_i) begin
          inst_o[6]  = 1'b1;
          inst_o[33] = 1'b1;
          if (pop_q == len_q - 1'b1) state_d = S_DONE;
          else                       pop_d   = pop_q + 1'b1;
        end
      end
      S_DONE: begin
        busy_o  = 1'b0;
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy_o  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef CORELET_CTRL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      perf_q <= '0;
    end else if (state_q == S_IDLE && start_i) begin
      perf_q <= '0;
    end else if (busy_o && perf_q != '1) begin
      perf_q <= perf_q + 1'b1;
    end
  end

  assign perf_cycles_o = perf_q;
`endif

endmodule

// File: tb/tb_corelet_ctrl.sv
// tb/tb_corelet_ctrl.sv - directed self-checking bench for corelet_ctrl
module tb_corelet_ctrl;

  localparam logic [33:0] INST_MASK = 34'h2_0000_004F;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [10:0] w_base = '0;
  logic [10:0] x_base = '0;
  logic [5:0]  len = '0;
  logic        mem_cen;
  logic [10:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic [33:0] inst;
  logic [31:0] l0_input;
  logic        xw_mode;
  logic        sfp_reset;
  logic        ofifo_valid = 1'b0;
  logic        busy;
  logic        done;
`ifdef CORELET_CTRL_PERF_EN
  logic [31:0] perf_cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;

  corelet_ctrl dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .start_i      (start),
    .w_base_i     (w_base),
    .x_base_i     (x_base),
    .len_i        (len),
    .mem_cen_o    (mem_cen),
    .mem_addr_o   (mem_addr),
    .mem_rdata_i  (mem_rdata),
    .inst_o       (inst),
    .l0_input_o   (l0_input),
    .xw_mode_o    (xw_mode),
    .sfp_reset_o  (sfp_reset),
    .ofifo_valid_i(ofifo_valid),
    .busy_o       (busy),
    .done_o       (done)
`ifdef CORELET_CTRL_PERF_EN
    ,.perf_cycles_o(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  // SRAM model: one-cycle read latency, data tagged with its address
  always @(posedge clk) if (!mem_cen) mem_rdata <= 32'hC0DE_0000 | {21'b0, mem_addr};

  bit          mon_en = 0;
  int          cyc, n_busy, n_l0wr, n_kload, n_flush, n_exec, n_pop, n_bad_pop, n_acc_err;
  int          n_lag_err, n_bad_bits, n_done, done_cyc, n_sfp, sfp_cyc, first_cen_cyc;
  int          n_l0_data_err, n_xw;
  logic [10:0] addrs[$];
  int          pop_cycs[$];
  bit          prev_cen_low;
  logic [10:0] prev_addr;

  always @(negedge clk) if (mon_en) begin
    cyc++;
    if (busy) n_busy++;
    if (xw_mode) n_xw++;
    if (inst[2]) begin
      n_l0wr++;
      if (l0_input !== (32'hC0DE_0000 | {21'b0, prev_addr})) n_l0_data_err++;
    end
    if (inst[2] !== prev_cen_low) n_lag_err++;
    if (inst[0] && inst[3]) n_kload++;
    if (inst[1] && inst[3]) n_exec++;
    if (busy && xw_mode && mem_cen && inst == '0) n_flush++;
    if (inst[6]) begin
      n_pop++;
      pop_cycs.push_back(cyc);
      if (!ofifo_valid) n_bad_pop++;
    end
    if (inst[6] !== inst[33]) n_acc_err++;
    if ((inst & ~INST_MASK) != '0) n_bad_bits++;
    if (done) begin n_done++; done_cyc = cyc; end
    if (sfp_reset) begin n_sfp++; sfp_cyc = cyc; end
    if (!mem_cen) begin
      addrs.push_back(mem_addr);
      if (first_cen_cyc == 0) first_cen_cyc = cyc;
    end
    prev_cen_low = !mem_cen;
    prev_addr    = mem_addr;
  end

  task automatic clear_mon();
    cyc = 0; n_busy = 0; n_l0wr = 0; n_kload = 0; n_flush = 0; n_exec = 0; n_pop = 0;
    n_bad_pop = 0; n_acc_err = 0; n_lag_err = 0; n_bad_bits = 0; n_done = 0; done_cyc = 0;
    n_sfp = 0; sfp_cyc = 0; first_cen_cyc = 0; n_l0_data_err = 0; n_xw = 0;
    prev_cen_low = 0; prev_addr = '0;
    addrs.delete();
    pop_cycs.delete();
  endtask

  // vmode 0: ofifo_valid tied 1; 1: 1-0-0-1 pattern from first DRAIN cycle; 2: tied 0
  task automatic run_pass(input logic [10:0] wb, input logic [10:0] xb, input logic [5:0] ln,
                          input int vmode, input int restart_at, input int abort_at,
                          input int budget);
    int nx, k, drain0;
    drain0 = 36 + 2 * int'(ln);
    @(posedge clk); #1;
    w_base = wb; x_base = xb; len = ln; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    clear_mon();
    mon_en = 1;
    for (int i = 0; i < budget; i++) begin
      nx = cyc + 1;
      k  = nx - drain0;
      ofifo_valid = (vmode == 0) ? 1'b1 :
                    (vmode == 2 || k < 0) ? 1'b0 : ((k % 4 == 0) || (k % 4 == 3));
      start = (restart_at != 0 && nx == restart_at);
      if (abort_at != 0 && nx == abort_at) begin
        #3 reset_n = 1'b0;
        break;
      end
      if (n_done != 0 && cyc >= done_cyc + 2) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
    ofifo_valid = 1'b0;
    if (abort_at == 0) mon_en = 0;
  endtask

  task automatic test_reset();
    int idle_err = 0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (mem_cen !== 1'b1) begin n_err++; $display("FAIL rst_mem_cen got %0b want 1", mem_cen); end
    n_cmp++; if (mem_addr !== 11'h0) begin n_err++; $display("FAIL rst_mem_addr got %0h want 0", mem_addr); end
    n_cmp++; if (inst !== 34'h0) begin n_err++; $display("FAIL rst_inst got %0h want 0", inst); end
    n_cmp++; if ({xw_mode, sfp_reset, busy, done} !== 4'b0) begin
      n_err++; $display("FAIL rst_flags got %b want 0000", {xw_mode, sfp_reset, busy, done});
    end
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if ({mem_cen, busy, done, sfp_reset, xw_mode} !== 5'b10000 || inst !== 34'h0) idle_err++;
    end
    n_cmp++; if (idle_err !== 0) begin n_err++; $display("FAIL idle_after_release got %0d want 0", idle_err); end
  endtask

  task automatic test_defaults();
    int aerr = 0;
    run_pass(11'h010, 11'h100, 6'd4, 0, 0, 0, 300);
    n_cmp++; if (addrs.size() !== 12) begin n_err++; $display("FAIL def_nreads got %0d want 12", addrs.size()); end
    else begin
      for (int i = 0; i < 8; i++) if (addrs[i] !== 11'h010 + 11'(i)) aerr++;
      for (int i = 0; i < 4; i++) if (addrs[8+i] !== 11'h100 + 11'(i)) aerr++;
      n_cmp++; if (aerr !== 0) begin n_err++; $display("FAIL def_addrs got %0d bad want 0", aerr); end
    end
    n_cmp++; if (n_l0wr !== 12) begin n_err++; $display("FAIL def_l0wr got %0d want 12", n_l0wr); end
    n_cmp++; if (n_kload !== 8) begin n_err++; $display("FAIL def_kload got %0d want 8", n_kload); end
    n_cmp++; if (n_flush !== 16) begin n_err++; $display("FAIL def_flush got %0d want 16", n_flush); end
    n_cmp++; if (n_xw !== 33) begin n_err++; $display("FAIL def_xw_cycles got %0d want 33", n_xw); end
    n_cmp++; if (n_exec !== 4) begin n_err++; $display("FAIL def_exec got %0d want 4", n_exec); end
    n_cmp++; if (n_pop !== 4) begin n_err++; $display("FAIL def_pops got %0d want 4", n_pop); end
    n_cmp++; if (n_done !== 1 || done_cyc !== 48) begin
      n_err++; $display("FAIL def_done got n=%0d cyc=%0d want n=1 cyc=48", n_done, done_cyc);
    end
    n_cmp++; if (n_busy !== 47) begin n_err++; $display("FAIL def_busy got %0d want 47", n_busy); end
    n_cmp++; if (n_sfp !== 1 || sfp_cyc !== 1) begin
      n_err++; $display("FAIL def_sfp got n=%0d cyc=%0d want n=1 cyc=1", n_sfp, sfp_cyc);
    end
    n_cmp++; if (first_cen_cyc !== 2) begin n_err++; $display("FAIL def_first_cen got %0d want 2", first_cen_cyc); end
    n_cmp++; if (n_lag_err !== 0) begin n_err++; $display("FAIL def_l0wr_lag got %0d want 0", n_lag_err); end
    n_cmp++; if (n_l0_data_err !== 0) begin n_err++; $display("FAIL def_l0_data got %0d want 0", n_l0_data_err); end
    n_cmp++; if (n_bad_bits !== 0 || n_acc_err !== 0) begin
      n_err++; $display("FAIL def_inst_bits got bad=%0d acc=%0d want 0 0", n_bad_bits, n_acc_err);
    end
`ifdef CORELET_CTRL_PERF_EN
    n_cmp++; if (perf_cycles !== 32'd47) begin n_err++; $display("FAIL def_perf got %0d want 47", perf_cycles); end
`endif
  endtask

  task automatic test_drain_toggle();
    run_pass(11'h020, 11'h200, 6'd3, 1, 0, 0, 300);
    n_cmp++; if (n_pop !== 3) begin n_err++; $display("FAIL tog_pops got %0d want 3", n_pop); end
    n_cmp++; if (pop_cycs.size() != 3 || pop_cycs[0] != 42 || pop_cycs[1] != 45 || pop_cycs[2] != 46) begin
      n_err++; $display("FAIL tog_pop_cycles got n=%0d want 42,45,46", pop_cycs.size());
    end
    n_cmp++; if (n_bad_pop !== 0) begin n_err++; $display("FAIL tog_bad_pop got %0d want 0", n_bad_pop); end
    n_cmp++; if (n_done !== 1 || done_cyc !== 47) begin
      n_err++; $display("FAIL tog_done got n=%0d cyc=%0d want n=1 cyc=47", n_done, done_cyc);
    end
  endtask

  task automatic test_len_zero();
    run_pass(11'h030, 11'h300, 6'd0, 0, 0, 0, 50);
    n_cmp++; if (n_done !== 1 || done_cyc !== 1) begin
      n_err++; $display("FAIL len0_done got n=%0d cyc=%0d want n=1 cyc=1", n_done, done_cyc);
    end
    n_cmp++; if (addrs.size() !== 0) begin n_err++; $display("FAIL len0_reads got %0d want 0", addrs.size()); end
    n_cmp++; if (n_sfp !== 0 || n_busy !== 0) begin
      n_err++; $display("FAIL len0_activity got sfp=%0d busy=%0d want 0 0", n_sfp, n_busy);
    end
  endtask

  task automatic test_restart_abort();
    run_pass(11'h040, 11'h140, 6'd4, 2, 41, 50, 300);
    #1;
    n_cmp++; if (mem_cen !== 1'b1 || mem_addr !== 11'h0 || inst !== 34'h0) begin
      n_err++; $display("FAIL abort_bus got cen=%0b addr=%0h inst=%0h want 1 0 0", mem_cen, mem_addr, inst);
    end
    n_cmp++; if ({xw_mode, sfp_reset, busy, done} !== 4'b0) begin
      n_err++; $display("FAIL abort_flags got %b want 0000", {xw_mode, sfp_reset, busy, done});
    end
    n_cmp++; if (n_sfp !== 1 || addrs.size() !== 12 || n_exec !== 4) begin
      n_err++; $display("FAIL restart_ignored got sfp=%0d reads=%0d exec=%0d want 1 12 4", n_sfp, addrs.size(), n_exec);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1 mon_en = 0;
    n_cmp++; if (n_done !== 0 || n_busy !== 49 || n_pop !== 0) begin
      n_err++; $display("FAIL abort_after got done=%0d busy=%0d pops=%0d want 0 49 0", n_done, n_busy, n_pop);
    end
  endtask

  task automatic test_wrap();
    run_pass(11'h050, 11'h7FE, 6'd4, 0, 0, 0, 300);
    n_cmp++; if (addrs.size() !== 12 || addrs[8] !== 11'h7FE || addrs[9] !== 11'h7FF ||
                 addrs[10] !== 11'h000 || addrs[11] !== 11'h001) begin
      n_err++; $display("FAIL wrap_addrs got n=%0d last=%0h want 12 001", addrs.size(),
                        addrs.size() > 0 ? addrs[addrs.size()-1] : 11'h0);
    end
    n_cmp++; if (n_done !== 1 || n_busy !== 47) begin
      n_err++; $display("FAIL wrap_done got done=%0d busy=%0d want 1 47", n_done, n_busy);
    end
`ifdef CORELET_CTRL_PERF_EN
    n_cmp++; if (perf_cycles !== 32'(n_busy)) begin
      n_err++; $display("FAIL wrap_perf got %0d want %0d", perf_cycles, n_busy);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_drain_toggle();
    test_len_zero();
    test_restart_abort();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/corelet_ctrl.md
# corelet_ctrl

Sequencer that drives one `corelet` through a complete tile pass: it fetches weights and activations from an activation/weight SRAM, generates the 34-bit `inst` bus, `l0_input`, `xw_mode` and `sfp_reset`, and pops the output FIFO into the SFP accumulator. It sits between the top-level core and the corelet and replaces hand-driven testbench instruction streams. A single `start`/`done` handshake runs one pass of `len` activation vectors against one `col`-column weight tile.

## Interface
- `bw`, 4, activation/weight element width
- `psum_bw`, 16, partial-sum width (for width consistency only)
- `row`, 8, MAC array rows; `l0_input` is `row*bw` bits
- `col`, 8, MAC array columns; number of weight words per tile
- `addr_bw`, 11, SRAM address width
- `len_bw`, 6, width of `len`
- `clk`  input  1  clock, all logic on rising edge
- `reset`  input  1  asynchronous, active-low reset
- `start`  input  1  one-cycle request to begin a pass
- `w_base`  input  addr_bw  SRAM address of first weight word
- `x_base`  input  addr_bw  SRAM address of first activation word
- `len`  input  len_bw  number of activation vectors, 1..2^len_bw-1
- `mem_cen`  output  1  SRAM chip enable, active-low
- `mem_addr`  output  addr_bw  SRAM read address
- `mem_rdata`  input  row*bw  SRAM read data, valid 1 cycle after `mem_cen` low
- `inst`  output  34  corelet instruction; [0] kernel load, [1] execute, [2] L0 wr, [3] L0 rd, [6] OFIFO rd, [33] SFP accumulate; all other bits 0
- `l0_input`  output  row*bw  combinational pass-through of `mem_rdata`
- `xw_mode`  output  1  1 in weight phases, 0 otherwise
- `sfp_reset`  output  1  active-high one-cycle SFP clear
- `ofifo_valid`  input  1  corelet OFIFO has a readable entry
- `busy`  output  1  high from start acceptance until `done`
- `done`  output  1  one-cycle pass-complete pulse

## Operation
- States: IDLE, WFETCH, WLOAD, WFLUSH, XFETCH, EXEC, DRAIN, DONE.
- IDLE: on `start`=1 and `len`!=0, latch `w_base`, `x_base`, `len`; pulse `sfp_reset`; go WFETCH. `start` with `len`=0 → DONE directly, no other activity. `start` outside IDLE ignored.
- WFETCH: issue `col` reads at `w_base`..`w_base+col-1` (`mem_cen`=0); each returned word is written to L0 (`inst[2]`=1) the following cycle; state lasts `col+1` cycles; `xw_mode`=1.
- WLOAD: `inst[3]`=`inst[0]`=1 for `col` cycles; `xw_mode`=1.
- WFLUSH: `inst`=0 for `row+col` cycles to let weights settle; `xw_mode`=1.
- XFETCH: as WFETCH but `len` reads from `x_base`, `len+1` cycles, `xw_mode`=0.
- EXEC: `inst[3]`=`inst[1]`=1 for `len` cycles.
- DRAIN: each cycle with `ofifo_valid`=1, assert `inst[6]`=`inst[33]`=1 (pop + accumulate); count pops; exit after `len` pops.
- DONE: `done`=1 one cycle, `busy`=0 same cycle, return IDLE.
- Address counters wrap modulo 2^addr_bw. Pop counter width `len_bw`.

## Timing
- Reset values: `mem_cen`=1, `mem_addr`=0, `inst`=0, `xw_mode`=0, `sfp_reset`=0, `busy`=0, `done`=0; state IDLE.
- `start` sampled at edge T → `sfp_reset`=1 and `busy`=1 during T+1; first `mem_cen`=0 at T+2.
- Fixed-phase cycles: `1 + (col+1) + col + (row+col) + (len+1) + len`; DRAIN variable (≥`len`); DONE 1.
- `inst[2]` asserted exactly one cycle after each `mem_cen`=0 cycle; never otherwise.
- `inst[6]` only when `ofifo_valid`=1 in the same cycle; never two pops past `len`.
- Reset asserted mid-pass: all outputs to reset values immediately, no `done`.
- DRAIN has no timeout; an absent `ofifo_valid` stalls indefinitely with `busy`=1.

## Configuration
- `CORELET_CTRL_PERF_EN` defined: adds output `perf_cycles` (32 bits), cleared on start acceptance, increments each cycle while `busy`, holds value after `done`, saturates at all-ones, resets to 0.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset: hold `reset`=0 → `mem_cen`=1, all other outputs 0; release, no `start` → outputs stay idle.
- Defaults, `w_base`=0x010, `x_base`=0x100, `len`=4, `ofifo_valid` tied 1 → addresses 0x010..0x017 then 0x100..0x103, 8 L0 writes, 8 kernel-load cycles, 16 flush, 4 L0 writes, 4 execute cycles, exactly 4 pops, `done` one cycle.
- `ofifo_valid` toggling 1-0-0-1 during DRAIN, `len`=3 → `inst[6]` only in valid cycles, `done` after third pop.
- `len`=0 → `done` one cycle after acceptance, `mem_cen` never low, `sfp_reset` never pulsed.
- `start` re-pulsed during EXEC, then `reset` dropped mid-DRAIN → second start ignored; reset clears everything, no `done`.
- `x_base`=0x7FE, `len`=4 → addresses 0x7FE, 0x7FF, 0x000, 0x001; with `CORELET_CTRL_PERF_EN`, `perf_cycles` equals measured `busy` cycle count.
